// File: rtl/instruction_decode_if.sv
// Bundle of all non-clock signals of the ID stage: the IF/ID word and the
// WB/MEM feedback going in, the ID/EX register and the branch/stall feedback to
// fetch coming out.
// There is no valid/ready pair. Every transfer happens on each rising clk
// edge. `stall` means "hold": fetch keeps IF/ID and the PC while ID/EX takes a
// bubble. `branch_taken` means "redirect": fetch loads branch_addr and zeroes
// IF/ID.
interface instruction_decode_if;
  logic [63:0] if_id_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        mem_reg_write;
  logic [4:0]  mem_dest;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        stall;
  logic [8:0]  id_ex_ctrl;
  logic [31:0] id_ex_rs_data;
  logic [31:0] id_ex_rt_data;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;
  logic [5:0]  id_ex_funct;
  logic [31:0] id_ex_pc;

  // The decode stage itself.
  modport slave (
    input  if_id_reg, wb_reg_write, wb_write_reg, wb_write_data,
           mem_reg_write, mem_dest,
    output branch_taken, branch_addr, stall, id_ex_ctrl, id_ex_rs_data,
           id_ex_rt_data, id_ex_imm, id_ex_rs, id_ex_rt, id_ex_rd,
           id_ex_funct, id_ex_pc
  );

  // The surrounding pipeline: the fetch, MEM and WB stages.
  modport master (
    output if_id_reg, wb_reg_write, wb_write_reg, wb_write_data,
           mem_reg_write, mem_dest,
    input  branch_taken, branch_addr, stall, id_ex_ctrl, id_ex_rs_data,
           id_ex_rt_data, id_ex_imm, id_ex_rs, id_ex_rt, id_ex_rd,
           id_ex_funct, id_ex_pc
  );
endinterface

// File: rtl/instruction_decode.sv
// ID stage of the five-stage pipeline. It contains the register file with a
// write-through bypass and the control decode. It resolves beq/bne/j early in
// ID and detects load-use and branch-operand hazards. It also holds the ID/EX
// pipeline register.
module instruction_decode (
  input  logic clk,
  input  logic rst_n,
  instruction_decode_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [31:0] instr;
  logic [31:0] pc;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [5:0]  funct;

  assign instr = bus.if_id_reg[63:32];
  assign pc    = bus.if_id_reg[31:0];
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign imm16 = instr[15:0];
  assign funct = instr[5:0];

  logic [31:0] regFile [32];
  logic [31:0] rsData;
  logic [31:0] rtData;

  logic [8:0]  idExCtrl;
  logic [31:0] idExRsData;
  logic [31:0] idExRtData;
  logic [31:0] idExImm;
  logic [4:0]  idExRs;
  logic [4:0]  idExRt;
  logic [4:0]  idExRd;
  logic [5:0]  idExFunct;
  logic [31:0] idExPc;

  // Register file. Reset clears every entry. Writes to $0 are dropped, so $0
  // stays zero even without the read-side guard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (bus.wb_reg_write && bus.wb_write_reg != 5'd0) begin
      regFile[bus.wb_write_reg] <= bus.wb_write_data;
    end
  end

  // Combinational reads. A same-cycle write-back is bypassed so ID sees the new value.
  always_comb begin
    rsData = regFile[rs];
    rtData = regFile[rt];
    if (rs == 5'd0)
      rsData = '0;
    else if (bus.wb_reg_write && bus.wb_write_reg == rs)
      rsData = bus.wb_write_data;
    if (rt == 5'd0)
      rtData = '0;
    else if (bus.wb_reg_write && bus.wb_write_reg == rt)
      rtData = bus.wb_write_data;
  end

  logic [8:0]  ctrl;
  logic [31:0] immExt;

  // Control vector {reg_write, mem_to_reg, mem_read, mem_write, alu_src,
  // reg_dst, alu_op[2:0]}. Branches, jumps, unknown opcodes and the all-zero
  // instruction are bubbles.
  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: ctrl = 9'b100001_111;
      OP_LW:    ctrl = 9'b111010_000;
      OP_SW:    ctrl = 9'b000110_000;
      OP_ADDI:  ctrl = 9'b100010_000;
      OP_ANDI:  ctrl = 9'b100010_010;
      OP_ORI:   ctrl = 9'b100010_011;
      OP_SLTI:  ctrl = 9'b100010_100;
      default:  ctrl = '0;
    endcase
    if (instr == 32'd0) ctrl = '0;
  end

  // Logical immediates are zero-extended. All other immediates are sign-extended.
  always_comb begin
    immExt = {{16{imm16[15]}}, imm16};
    if (op == OP_ANDI || op == OP_ORI) immExt = {16'd0, imm16};
  end

  logic        isBeq;
  logic        isBne;
  logic        isJ;
  logic [31:0] pcPlus4;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [4:0]  exDest;
  logic        loadUse;
  logic        rsBranchHaz;
  logic        rtBranchHaz;
  logic        branchHaz;
  logic        stallInt;
  logic        takenInt;

  assign isBeq        = (op == OP_BEQ);
  assign isBne        = (op == OP_BNE);
  assign isJ          = (op == OP_J);
  assign pcPlus4      = pc + 32'd4;
  assign branchTarget = pcPlus4 + {immExt[29:0], 2'b00};
  assign jumpTarget   = {pcPlus4[31:28], instr[25:0], 2'b00};

  // Hazard detection. A load in EX blocks any reader of its rt. A branch must
  // wait until both of its operands can come from the register file or the
  // bypass, so it waits while a producer is still in EX or in MEM.
  always_comb begin
    exDest      = idExCtrl[3] ? idExRd : idExRt;
    loadUse     = idExCtrl[6] && (idExRt != 5'd0) &&
                  ((idExRt == rs) || (idExRt == rt));
    rsBranchHaz = (rs != 5'd0) &&
                  ((idExCtrl[8] && exDest == rs) ||
                   (bus.mem_reg_write && bus.mem_dest == rs));
    rtBranchHaz = (rt != 5'd0) &&
                  ((idExCtrl[8] && exDest == rt) ||
                   (bus.mem_reg_write && bus.mem_dest == rt));
    branchHaz   = (isBeq || isBne) && (rsBranchHaz || rtBranchHaz);
    stallInt    = loadUse || branchHaz;
  end

  // Early branch resolution. A stalled branch has stale operands, so it never redirects.
  always_comb begin
    takenInt = 1'b0;
    if (!stallInt)
      takenInt = isJ || (isBeq && rsData == rtData) || (isBne && rsData != rtData);
    bus.branch_addr = isJ ? jumpTarget : branchTarget;
  end

  assign bus.branch_taken = takenInt;
  assign bus.stall        = stallInt;

  // ID/EX register. Reset wins. A stall inserts an all-zero bubble. Otherwise
  // the decoded instruction is loaded; a taken branch loads ctrl=0 because
  // branches decode that way.
  always_ff @(posedge clk) begin
    if (!rst_n || stallInt) begin
      idExCtrl   <= '0;
      idExRsData <= '0;
      idExRtData <= '0;
      idExImm    <= '0;
      idExRs     <= '0;
      idExRt     <= '0;
      idExRd     <= '0;
      idExFunct  <= '0;
      idExPc     <= '0;
    end else begin
      idExCtrl   <= ctrl;
      idExRsData <= rsData;
      idExRtData <= rtData;
      idExImm    <= immExt;
      idExRs     <= rs;
      idExRt     <= rt;
      idExRd     <= rd;
      idExFunct  <= funct;
      idExPc     <= pc;
    end
  end

  assign bus.id_ex_ctrl    = idExCtrl;
  assign bus.id_ex_rs_data = idExRsData;
  assign bus.id_ex_rt_data = idExRtData;
  assign bus.id_ex_imm     = idExImm;
  assign bus.id_ex_rs      = idExRs;
  assign bus.id_ex_rt      = idExRt;
  assign bus.id_ex_rd      = idExRd;
  assign bus.id_ex_funct   = idExFunct;
  assign bus.id_ex_pc      = idExPc;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode. Each step drives one IF/ID word plus
// the WB/MEM feedback. It checks stall/branch_taken/branch_addr before the
// edge, and it checks the ID/EX register one cycle later against the expected
// queue.
module tb_instruction_decode;

  localparam int W = 158;  // {ctrl9, rs_data, rt_data, imm, rs, rt, rd, funct6, pc}

  localparam logic [8:0] C_R    = 9'b100001_111;
  localparam logic [8:0] C_LW   = 9'b111010_000;
  localparam logic [8:0] C_SW   = 9'b000110_000;
  localparam logic [8:0] C_ADDI = 9'b100010_000;
  localparam logic [8:0] C_ORI  = 9'b100010_011;
  localparam logic [8:0] C_SLTI = 9'b100010_100;
  localparam logic [8:0] C_NONE = 9'b000000_000;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;
  logic [W-1:0] exp_q[$];

  instruction_decode_if bus();

  instruction_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] i);
    return {o, s, t, i};
  endfunction

  function automatic logic [W-1:0] mk(input logic [8:0] c, input logic [31:0] sd,
                                      input logic [31:0] td, input logic [31:0] im,
                                      input logic [4:0] s, input logic [4:0] t,
                                      input logic [4:0] d, input logic [5:0] f,
                                      input logic [31:0] p);
    return {c, sd, td, im, s, t, d, f, p};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.id_ex_ctrl, bus.id_ex_rs_data, bus.id_ex_rt_data, bus.id_ex_imm,
            bus.id_ex_rs, bus.id_ex_rt, bus.id_ex_rd, bus.id_ex_funct, bus.id_ex_pc};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Scoreboard: pop the oldest expected ID/EX image and compare it.
  task automatic check_id_ex(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      $error("FAIL %s_q observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_idex"}, observed(), e);
    end
  endtask

  // Driver: one pipeline cycle. Entered just after a rising edge.
  task automatic cycle(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic wbEn, input logic [4:0] wbReg, input logic [31:0] wbData,
                       input logic memEn, input logic [4:0] memDest,
                       input logic expStall, input logic expTaken, input logic [31:0] expAddr,
                       input logic [W-1:0] expIdEx);
    bus.if_id_reg     = {instr, pc};
    bus.wb_reg_write  = wbEn;
    bus.wb_write_reg  = wbReg;
    bus.wb_write_data = wbData;
    bus.mem_reg_write = memEn;
    bus.mem_dest      = memDest;
    #2;
    chk({tag, "_stall"}, W'(bus.stall), W'(expStall));
    chk({tag, "_taken"}, W'(bus.branch_taken), W'(expTaken));
    if (expTaken) chk({tag, "_addr"}, W'(bus.branch_addr), W'(expAddr));
    exp_q.push_back(expIdEx);
    @(posedge clk);
    #1;
    check_id_ex(tag);
  endtask

  initial begin
    logic [31:0] addR;
    logic [31:0] beq6;
    logic [W-1:0] zero;
    checks = 0;
    passed = 0;
    zero   = '0;
    rst_n  = 1'b0;
    bus.if_id_reg     = '0;
    bus.wb_reg_write  = 1'b0;
    bus.wb_write_reg  = '0;
    bus.wb_write_data = '0;
    bus.mem_reg_write = 1'b0;
    bus.mem_dest      = '0;
    @(posedge clk);
    #1;

    // Reset: a pending lw must not reach ID/EX while rst_n is low.
    cycle("reset", itype(6'h23, 5'd1, 5'd2, 16'h0), 32'h0, 1'b0, 5'd0, 32'd0,
          1'b0, 5'd0, 1'b0, 1'b0, 32'd0, zero);
    rst_n = 1'b1;

    // Write $3 = 0x11 while decoding a bubble.
    cycle("wb3", 32'd0, 32'd0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, zero);
    // addi $4,$3,5; WB writes $1 = 0x20 in the same cycle.
    cycle("addi", 32'h2064_0005, 32'h100, 1'b1, 5'd1, 32'h20, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0,
          mk(C_ADDI, 32'h11, 32'h0, 32'h5, 5'd3, 5'd4, 5'd0, 6'h05, 32'h100));

    // Load-use: lw $2,0($1) then add $5,$2,$2 stalls exactly one cycle.
    cycle("lw", itype(6'h23, 5'd1, 5'd2, 16'h0), 32'h104, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
          1'b0, 1'b0, 32'd0, mk(C_LW, 32'h20, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 6'h00, 32'h104));
    addR = rtype(5'd2, 5'd2, 5'd5, 6'h20);
    cycle("lu_stall", addR, 32'h108, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'd0, zero);
    // The add issues now. WB writes $2 = 7, which reaches it through the bypass.
    cycle("lu_issue", addR, 32'h108, 1'b1, 5'd2, 32'h7, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0,
          mk(C_R, 32'h7, 32'h7, 32'h2820, 5'd2, 5'd2, 5'd5, 6'h20, 32'h108));
    cycle("wb1", 32'd0, 32'd0, 1'b1, 5'd1, 32'h7, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, zero);

    // beq $1,$2,+3 at 0x40 with equal operands, then bne.
    cycle("beq", itype(6'h04, 5'd1, 5'd2, 16'd3), 32'h40, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
          1'b0, 1'b1, 32'h50, mk(C_NONE, 32'h7, 32'h7, 32'h3, 5'd1, 5'd2, 5'd0, 6'h03, 32'h40));
    cycle("bne", itype(6'h05, 5'd1, 5'd2, 16'd3), 32'h40, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
          1'b0, 1'b0, 32'd0, mk(C_NONE, 32'h7, 32'h7, 32'h3, 5'd1, 5'd2, 5'd0, 6'h03, 32'h40));

    // j 0x100 at 0x1000_0000.
    cycle("jump", 32'h0800_0100, 32'h1000_0000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
          1'b0, 1'b1, 32'h1000_0400,
          mk(C_NONE, 32'h0, 32'h0, 32'h100, 5'd0, 5'd0, 5'd0, 6'h00, 32'h1000_0000));

    // add $6,$7,$8, then beq $6,$0. The branch waits while the add is in EX and
    // in MEM, then resolves with the write-back bypass.
    cycle("add6", rtype(5'd7, 5'd8, 5'd6, 6'h20), 32'h200, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
          1'b0, 1'b0, 32'd0, mk(C_R, 32'h0, 32'h0, 32'h3020, 5'd7, 5'd8, 5'd6, 6'h20, 32'h200));
    beq6 = itype(6'h04, 5'd6, 5'd0, 16'd1);
    cycle("bh_ex", beq6, 32'h204, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'd0, zero);
    cycle("bh_mem", beq6, 32'h204, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b1, 1'b0, 32'd0, zero);
    cycle("bh_go", beq6, 32'h204, 1'b1, 5'd6, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h20C,
          mk(C_NONE, 32'h0, 32'h0, 32'h1, 5'd6, 5'd0, 5'd0, 6'h01, 32'h204));

    // lw $6 then beq $6,$0. It stalls two cycles, and no redirect is allowed
    // although the operands are equal.
    cycle("lw6", itype(6'h23, 5'd0, 5'd6, 16'h0), 32'h300, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
          1'b0, 1'b0, 32'd0, mk(C_LW, 32'h0, 32'h0, 32'h0, 5'd0, 5'd6, 5'd0, 6'h00, 32'h300));
    cycle("lbh_ex", beq6, 32'h304, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'd0, zero);
    cycle("lbh_mem", beq6, 32'h304, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b1, 1'b0, 32'd0, zero);
    cycle("lbh_go", beq6, 32'h304, 1'b1, 5'd6, 32'h99, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0,
          mk(C_NONE, 32'h99, 32'h0, 32'h1, 5'd6, 5'd0, 5'd0, 6'h01, 32'h304));

    // Same-cycle WB of $9 is seen by the read.
    cycle("bypass9", rtype(5'd9, 5'd0, 5'd10, 6'h20), 32'h400, 1'b1, 5'd9, 32'hDEAD_BEEF,
          1'b0, 5'd0, 1'b0, 1'b0, 32'd0,
          mk(C_R, 32'hDEAD_BEEF, 32'h0, 32'h5020, 5'd9, 5'd0, 5'd10, 6'h20, 32'h400));
    // A write to $0 is neither bypassed nor stored.
    cycle("wr0", rtype(5'd0, 5'd0, 5'd11, 6'h20), 32'h404, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0,
          1'b0, 1'b0, 32'd0,
          mk(C_R, 32'h0, 32'h0, 32'h5820, 5'd0, 5'd0, 5'd11, 6'h20, 32'h404));
    cycle("rd0", rtype(5'd0, 5'd0, 5'd11, 6'h20), 32'h408, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
          1'b0, 1'b0, 32'd0,
          mk(C_R, 32'h0, 32'h0, 32'h5820, 5'd0, 5'd0, 5'd11, 6'h20, 32'h408));

    // Remaining opcodes: ori (zero-extend), slti (sign-extend), sw, unknown opcode.
    cycle("ori", itype(6'h0D, 5'd9, 5'd12, 16'h8000), 32'h40C, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
          1'b0, 1'b0, 32'd0,
          mk(C_ORI, 32'hDEAD_BEEF, 32'h0, 32'h0000_8000, 5'd9, 5'd12, 5'd16, 6'h00, 32'h40C));
    cycle("slti", itype(6'h0A, 5'd9, 5'd13, 16'hFFFF), 32'h410, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
          1'b0, 1'b0, 32'd0,
          mk(C_SLTI, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 5'd9, 5'd13, 5'd31, 6'h3F, 32'h410));
    cycle("sw", itype(6'h2B, 5'd0, 5'd9, 16'h4), 32'h414, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
          1'b0, 1'b0, 32'd0,
          mk(C_SW, 32'h0, 32'hDEAD_BEEF, 32'h4, 5'd0, 5'd9, 5'd0, 6'h04, 32'h414));
    cycle("badop", 32'hFC22_1234, 32'h418, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0,
          mk(C_NONE, 32'h7, 32'h7, 32'h1234, 5'd1, 5'd2, 5'd2, 6'h34, 32'h418));

    // Reset during a load-use stall clears ID/EX and the register file.
    cycle("lw_b", itype(6'h23, 5'd1, 5'd2, 16'h0), 32'h500, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
          1'b0, 1'b0, 32'd0, mk(C_LW, 32'h7, 32'h7, 32'h0, 5'd1, 5'd2, 5'd0, 6'h00, 32'h500));
    rst_n = 1'b0;
    cycle("rst_mid", addR, 32'h108, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'd0, zero);
    rst_n = 1'b1;
    cycle("post_rst", addR, 32'h108, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0,
          mk(C_R, 32'h0, 32'h0, 32'h2820, 5'd2, 5'd2, 5'd5, 6'h20, 32'h108));

    // Final report: every expected entry must have been consumed.
    checks++;
    assert (exp_q.size() == 0) passed++;
    else $error("FAIL q_drain observed=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
